multiword_add_ctrl: RTL

Sequencer that performs WIDTH*WORDS-bit add/subtract by time-multiplexing one `adder #(WIDTH)` instance over WORDS cycles, chaining the carry through a register between words. It sits between an operand producer and a result consumer with valid/ready handshakes on both sides. It is the team's route to wide arithmetic without instantiating a wide ripple chain.

---
 rtl/multiword_add_ctrl.sv | 127 ++++++++++++
 1 files changed

// File: rtl/multiword_add_ctrl.sv
// Wide add/subtract sequencer: one WIDTH-bit adder reused over WORDS cycles,
// with the carry chained between words through a register.

module adder #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout
);

  assign {cout, y} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

module multiword_add_ctrl #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned WORDS = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*WORDS-1:0] op_a,
  input  logic [WIDTH*WORDS-1:0] op_b,
  input  logic                   cin_i,
  input  logic                   sub,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [WIDTH*WORDS-1:0] sum,
  output logic                   cout,
  output logic                   ovf
);

  localparam int unsigned N  = WIDTH * WORDS;
  localparam int unsigned KW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [KW-1:0] KLast = KW'(WORDS - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    a_q, b_q, sum_q;
  logic [KW-1:0]   k_q;
  logic            carry_q, cout_q, ovf_q;
  logic            accept, step, last;
  logic [WIDTH-1:0] word_a, word_b, word_y;
  logic            word_co;

  assign word_a = a_q[k_q*WIDTH +: WIDTH];
  assign word_b = b_q[k_q*WIDTH +: WIDTH];

  adder #(
    .WIDTH (WIDTH)
  ) u_adder (
    .a    (word_a),
    .b    (word_b),
    .cin  (carry_q),
    .y    (word_y),
    .cout (word_co)
  );

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    step    = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          accept  = 1'b1;
          state_d = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (k_q == KLast) begin
          last    = 1'b1;
          state_d = StDone;
        end
      end
      StDone: begin
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      k_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= op_a;
        // Subtraction is A + ~B + 1: invert B once and seed the carry.
        b_q     <= sub ? ~op_b : op_b;
        carry_q <= sub | cin_i;
        k_q     <= '0;
      end
      if (step) begin
        sum_q[k_q*WIDTH +: WIDTH] <= word_y;
        carry_q                   <= word_co;
        k_q                       <= last ? '0 : k_q + 1'b1;
      end
      if (last) begin
        cout_q <= word_co;
        ovf_q  <= (a_q[N-1] == b_q[N-1]) && (word_y[WIDTH-1] != a_q[N-1]);
      end
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule
